// File: rtl/ok_trigger_in_multi.sv
// Packet-driven trigger endpoint bank: HEADER, length, then addr/bit commands; fires pending bits on completion.
// trig_out asserts the cycle after the last command word for PULSE_CYCLES cycles; there is no backpressure, and words in FIRE are dropped.
module ok_trigger_in_multi #(
  parameter logic [15:0] HEADER       = 16'hC7E5,
  parameter logic [7:0]  EP_BASE      = 8'h40,
  parameter int          NUM_EP       = 4,
  parameter int          TRIG_WIDTH   = 16,
  parameter int          MAX_WORDS    = 16,
  parameter int          PULSE_CYCLES = 1,
  parameter int          TIMEOUT      = 256
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic                         data_valid,
  input  logic [15:0]                  ok2,
  output logic [NUM_EP*TRIG_WIDTH-1:0] trig_out,
  output logic [1:0]                   STATE,
  output logic                         pkt_done,
  output logic                         pkt_err
);

  localparam int EP_END = int'(EP_BASE) + NUM_EP;
  localparam logic [7:0]  PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(TIMEOUT - 1);

  if (EP_END > 256 || NUM_EP < 1 || NUM_EP > 16 || TRIG_WIDTH < 1 || TRIG_WIDTH > 16 ||
      MAX_WORDS < 1 || MAX_WORDS > 255 || PULSE_CYCLES < 1 || PULSE_CYCLES > 255 ||
      TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
    $error("ok_trigger_in_multi: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, LEN = 2'd1, CMD = 2'd2, FIRE = 2'd3} state_t;

  state_t                        state, state_nxt;
  logic [15:0]                   w;
  logic [7:0]                    rem_cnt;
  logic [15:0]                   idle_cnt;
  logic [7:0]                    pulse_cnt;
  logic [NUM_EP*TRIG_WIDTH-1:0]  pending;
  logic [NUM_EP*TRIG_WIDTH-1:0]  set_mask;
  logic [7:0]                    ep_off;
  logic                          cmd_hit, len_ok, timed_out;
  logic                          load_len, consume, abort, fire_end;

  assign w         = {ok2[7:0], ok2[15:8]};
  assign ep_off    = w[15:8] - EP_BASE;
  assign cmd_hit   = ({1'b0, w[15:8]} >= {1'b0, EP_BASE}) && ({1'b0, w[15:8]} < 9'(EP_END)) &&
                     (w[7:0] < 8'(TRIG_WIDTH));
  assign len_ok    = (w[7:0] != 8'd0) && (w[7:0] <= 8'(MAX_WORDS));
  assign timed_out = (idle_cnt == IDLE_LAST);

  always_comb begin
    set_mask = '0;
    for (int k = 0; k < NUM_EP; k++) begin
      for (int b = 0; b < TRIG_WIDTH; b++) begin
        if (cmd_hit && ep_off == 8'(k) && w[7:0] == 8'(b)) set_mask[k*TRIG_WIDTH+b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_len  = 1'b0;
    consume   = 1'b0;
    abort     = 1'b0;
    fire_end  = 1'b0;
    trig_out  = '0;
    pkt_done  = 1'b0;
    case (state)
      IDLE: if (data_valid && w == HEADER) state_nxt = LEN;
      LEN: begin
        if (data_valid) begin
          if (len_ok) begin
            load_len  = 1'b1;
            state_nxt = CMD;
          end else begin
            abort     = 1'b1;
            state_nxt = IDLE;
          end
        end else if (timed_out) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      CMD: begin
        if (data_valid) begin
          consume = 1'b1;
          if (rem_cnt == 8'd1) state_nxt = FIRE;
        end else if (timed_out) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      FIRE: begin
        trig_out = pending;
        pkt_done = (pulse_cnt == 8'd0);
        if (pulse_cnt == PULSE_LAST) begin
          fire_end  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Idle count only runs while a packet is open; any accepted word restarts it.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rem_cnt   <= '0;
      idle_cnt  <= '0;
      pulse_cnt <= '0;
      pending   <= '0;
      pkt_err   <= 1'b0;
    end else begin
      pkt_err <= abort;
      if (load_len)     rem_cnt <= w[7:0];
      else if (consume) rem_cnt <= rem_cnt - 8'd1;
      idle_cnt  <= ((state == LEN || state == CMD) && !data_valid && !abort) ? idle_cnt + 16'd1 : 16'd0;
      pulse_cnt <= (state == FIRE && !fire_end) ? pulse_cnt + 8'd1 : 8'd0;
      if (abort || fire_end) pending <= '0;
      else if (consume)      pending <= pending | set_mask;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_ok_trigger_in_multi.sv
// Bench for ok_trigger_in_multi: default instance driven from a vector table with an event scoreboard,
// plus a PULSE_CYCLES=4 instance for pulse-length and reset-in-FIRE sequences.
module tb_ok_trigger_in_multi;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        v0, v4;
  logic [15:0] ok0, ok4;
  logic [63:0] trig0, trig4;
  logic [1:0]  st0, st4;
  logic        done0, err0, done4, err4;

  always #5 clk_in = ~clk_in;

  ok_trigger_in_multi u_dut (
    .clk_in(clk_in), .rst_n(rst_n), .data_valid(v0), .ok2(ok0),
    .trig_out(trig0), .STATE(st0), .pkt_done(done0), .pkt_err(err0)
  );

  ok_trigger_in_multi #(.PULSE_CYCLES(4)) u_dut4 (
    .clk_in(clk_in), .rst_n(rst_n), .data_valid(v4), .ok2(ok4),
    .trig_out(trig4), .STATE(st4), .pkt_done(done4), .pkt_err(err4)
  );

  typedef struct packed {
    logic [63:0] trig;
    logic        err;
  } exp_t;

  typedef struct {
    string           name;
    int              n;
    logic [17:0][15:0] w;
    logic [63:0]     trig;
    logic            err;
  } vec_t;

  exp_t sb[$];
  vec_t vt[10];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic w0(input logic [15:0] w);
    @(negedge clk_in);
    v0  = 1'b1;
    ok0 = {w[7:0], w[15:8]};
  endtask

  task automatic gap0(input int n);
    repeat (n) begin
      @(negedge clk_in);
      v0  = 1'b0;
      ok0 = 16'($urandom);
    end
  endtask

  task automatic w4(input logic [15:0] w);
    @(negedge clk_in);
    v4  = 1'b1;
    ok4 = {w[7:0], w[15:8]};
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      gap0(1);
    end
    gap0(1);
    check({"drain_", name}, 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard: every pkt_done/pkt_err pulse must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (rst_n) begin
      exp_t e;
      if (st0 != 2'd3) check("trig0_outside_fire", trig0, 64'd0);
      if (st4 != 2'd3) check("trig4_outside_fire", trig4, 64'd0);
      if (done0 || err0) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {62'd0, done0, err0}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("evt_err", 64'(err0), 64'(e.err));
          check("evt_done", 64'(done0), 64'(!e.err));
          if (!e.err) check("evt_trig", trig0, e.trig);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; v4 = 1'b0; ok0 = '0; ok4 = '0;

    vt[0] = '{"basic",    4, 288'({16'h4300, 16'h4103, 16'h0002, 16'hC7E5}), 64'h0001_0000_0008_0000, 1'b0};
    vt[1] = '{"len0",     2, 288'({16'h0000, 16'hC7E5}), 64'd0, 1'b1};
    vt[2] = '{"len17",    2, 288'({16'h0011, 16'hC7E5}), 64'd0, 1'b1};
    vt[3] = '{"oor",      4, 288'({16'h4020, 16'h4410, 16'h0002, 16'hC7E5}), 64'd0, 1'b0};
    vt[4] = '{"dup",      5, 288'({16'h400F, 16'h4205, 16'h4205, 16'h0003, 16'hC7E5}), 64'h0000_0020_0000_8000, 1'b0};
    vt[5] = '{"junk",     4, 288'({16'h4001, 16'h0001, 16'hC7E5, 16'h1234}), 64'h2, 1'b0};
    vt[6] = '{"hi_len",   3, 288'({16'h430F, 16'hAB01, 16'hC7E5}), 64'h8000_0000_0000_0000, 1'b0};
    vt[7] = '{"hdr_data", 4, 288'({16'h4002, 16'hC7E5, 16'h0002, 16'hC7E5}), 64'h4, 1'b0};
    vt[8] = '{"edge_addr",4, 288'({16'h4300, 16'h3F00, 16'h0002, 16'hC7E5}), 64'h0001_0000_0000_0000, 1'b0};
    vt[9] = '{"maxlen",  18, 288'({16'h0010, 16'hC7E5}), 64'h1111_1111_1111_1111, 1'b0};
    for (int i = 0; i < 16; i++) vt[9].w[i+2] = {8'(8'h40 + i / 4), 8'(4 * (i % 4))};

    @(negedge clk_in);
    check("rst_state0", 64'(st0), 64'd0);
    check("rst_trig0", trig0, 64'd0);
    check("rst_flags0", {62'd0, done0, err0}, 64'd0);
    check("rst_state4", 64'(st4), 64'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    gap0(2);

    // Table-driven packets with random idle gaps between words.
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{vt[i].trig, vt[i].err});
      for (int j = 0; j < vt[i].n; j++) begin
        w0(vt[i].w[j]);
        gap0($urandom_range(0, 3));
      end
      drain(vt[i].name);
      check({"idle_", vt[i].name}, 64'(st0), 64'd0);
    end

    // Back-to-back basic packet: FIRE for one cycle, then IDLE.
    sb.push_back('{64'h0001_0000_0008_0000, 1'b0});
    w0(16'hC7E5); w0(16'h0002); w0(16'h4103); w0(16'h4300);
    gap0(1);
    check("b2b_state_fire", 64'(st0), 64'd3);
    check("b2b_trig", trig0, 64'h0001_0000_0008_0000);
    check("b2b_done", 64'(done0), 64'd1);
    gap0(1);
    check("b2b_state_idle", 64'(st0), 64'd0);
    check("b2b_trig_clear", trig0, 64'd0);
    drain("b2b");

    // Timeout: 255 idle cycles keep CMD, the 256th aborts.
    sb.push_back('{64'd0, 1'b1});
    w0(16'hC7E5); w0(16'h0003); w0(16'h4001);
    gap0(1);
    gap0(255);
    check("to_still_cmd", 64'(st0), 64'd2);
    gap0(1);
    check("to_err", 64'(err0), 64'd1);
    check("to_state", 64'(st0), 64'd0);
    drain("timeout");
    sb.push_back('{64'h0000_0000_0001_0000, 1'b0});
    w0(16'hC7E5); w0(16'h0001); w0(16'h4100);
    drain("after_timeout");

    // Four-cycle pulse with a HEADER word presented during FIRE.
    w4(16'hC7E5); w4(16'h0001); w4(16'h400F);
    @(negedge clk_in);
    v4 = 1'b1; ok4 = 16'hE5C7;
    check("p4_c1_trig", trig4, 64'h8000);
    check("p4_c1_done", 64'(done4), 64'd1);
    check("p4_c1_state", 64'(st4), 64'd3);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk_in);
      v4 = (c == 4);
      check("p4_trig", trig4, 64'h8000);
      check("p4_done", 64'(done4), 64'd0);
    end
    @(negedge clk_in);
    v4 = 1'b0;
    check("p4_end_state", 64'(st4), 64'd0);
    check("p4_end_trig", trig4, 64'd0);
    @(negedge clk_in);
    check("p4_hdr_ignored", 64'(st4), 64'd0);

    // Reset during CMD, release with a HEADER presented on the first edge.
    w0(16'hC7E5); w0(16'h0002); w0(16'h4001);
    gap0(1);
    #2 rst_n = 1'b0;
    #1;
    check("rcmd_state", 64'(st0), 64'd0);
    check("rcmd_flags", {62'd0, done0, err0}, 64'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    v0 = 1'b1; ok0 = 16'hE5C7;
    sb.push_back('{64'h0004_0000_0000_0000, 1'b0});
    w0(16'h0001); w0(16'h4302);
    drain("after_rst_cmd");

    // Reset during FIRE on the four-cycle instance.
    w4(16'hC7E5); w4(16'h0001); w4(16'h4001);
    @(negedge clk_in);
    v4 = 1'b0;
    check("rfire_in_fire", 64'(st4), 64'd3);
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("rfire_trig", trig4, 64'd0);
    check("rfire_state", 64'(st4), 64'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (6) @(negedge clk_in);
    check("rfire_no_residual_state", 64'(st4), 64'd0);
    check("rfire_no_residual_trig", trig4, 64'd0);

    gap0(3);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
